// File: rtl/ibex_fp_pkg.sv
// Shared FP writeback types: register count and the buffered result entry.
// Pure type/constant package, no logic.
package ibex_fp_pkg;

   localparam int FP_NUM_REGS = 32;
   localparam int FP_DATA_W   = 32;

   typedef struct packed {
      logic [4:0]           rd;
      logic [FP_DATA_W-1:0] wdata;
   } fp_wb_entry_t;

endpackage

// File: rtl/ibex_fp_writeback_if.sv
// Result/issue paths into the FP writeback stage and its register-file write port.
// "slave" is the writeback block's view; "master" is the surrounding pipeline.
interface ibex_fp_writeback_if #(
   parameter int DataWidth = 32
);

   logic                 issue_valid_i;
   logic [4:0]           issue_rd_i;
   logic                 fpu_valid_i;
   logic                 fpu_ready_o;
   logic [4:0]           fpu_rd_i;
   logic [DataWidth-1:0] fpu_wdata_i;
   logic                 lsu_valid_i;
   logic [4:0]           lsu_rd_i;
   logic [DataWidth-1:0] lsu_wdata_i;
   logic [4:0]           rf_waddr_o;
   logic [DataWidth-1:0] rf_wdata_o;
   logic                 rf_we_o;
   logic [31:0]          pending_o;
   logic                 busy_o;

   modport slave (
      input  issue_valid_i, issue_rd_i,
      input  fpu_valid_i, fpu_rd_i, fpu_wdata_i,
      output fpu_ready_o,
      input  lsu_valid_i, lsu_rd_i, lsu_wdata_i,
      output rf_waddr_o, rf_wdata_o, rf_we_o, pending_o, busy_o
   );

   modport master (
      output issue_valid_i, issue_rd_i,
      output fpu_valid_i, fpu_rd_i, fpu_wdata_i,
      input  fpu_ready_o,
      output lsu_valid_i, lsu_rd_i, lsu_wdata_i,
      input  rf_waddr_o, rf_wdata_o, rf_we_o, pending_o, busy_o
   );

endinterface

// File: rtl/ibex_fp_wb_fifo.sv
// FPU result buffer: synchronous FIFO of fp_wb_entry_t, head visible combinationally.
// Caller must not push when full or pop when empty; full/empty reflect registered count only.
module ibex_fp_wb_fifo
   import ibex_fp_pkg::*;
#(
   parameter int Depth = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push,
   input  fp_wb_entry_t push_data,
   input  logic         pop,
   output fp_wb_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   fp_wb_entry_t    mem [Depth];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic [CntW-1:0] count;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CntW'(push) - CntW'(pop);
      end
   end

   // Storage needs no reset: entries are only observed once count says they are valid.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CntW'(Depth));
   assign empty = (count == '0);

endmodule

// File: rtl/ibex_fp_writeback.sv
// Drives the FP register-file write port from LSU (priority, never stalled) and buffered FPU results.
// One-cycle registered write latency; FPU is backpressured only when the result FIFO is full.
module ibex_fp_writeback
   import ibex_fp_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int FifoDepth = 2
) (
   input logic                clk_i,
   input logic                rst_ni,
   ibex_fp_writeback_if.slave wb
);

   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fpu_fire;
   logic                   sel_valid;
   logic                   sel_write;
   fp_wb_entry_t           fpu_entry;
   fp_wb_entry_t           lsu_entry;
   fp_wb_entry_t           fifo_head;
   fp_wb_entry_t           sel;

   logic                   rf_we_q;
   logic [4:0]             rf_waddr_q;
   logic [DataWidth-1:0]   rf_wdata_q;
   logic [FP_NUM_REGS-1:0] pending_q;
   logic [FP_NUM_REGS-1:0] pending_d;
   logic [FP_NUM_REGS-1:0] set_mask;
   logic [FP_NUM_REGS-1:0] clr_mask;

   assign wb.fpu_ready_o = !fifo_full;
   assign fpu_fire       = wb.fpu_valid_i & !fifo_full;
   assign fpu_entry      = '{rd: wb.fpu_rd_i, wdata: wb.fpu_wdata_i};
   assign lsu_entry      = '{rd: wb.lsu_rd_i, wdata: wb.lsu_wdata_i};

   ibex_fp_wb_fifo #(
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (fifo_push),
      .push_data (fpu_entry),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // LSU cannot be stalled so it always wins; an FPU result only bypasses when nothing is queued ahead.
   always_comb begin
      sel       = fpu_entry;
      sel_valid = fpu_fire;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      if (wb.lsu_valid_i) begin
         sel       = lsu_entry;
         sel_valid = 1'b1;
         fifo_push = fpu_fire;
      end else if (!fifo_empty) begin
         sel       = fifo_head;
         sel_valid = 1'b1;
         fifo_pop  = 1'b1;
         fifo_push = fpu_fire;
      end
   end

   assign sel_write = sel_valid && (sel.rd != 5'd0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_we_q <= sel_write;
         if (sel_write) begin
            rf_waddr_q <= sel.rd;
            rf_wdata_q <= sel.wdata;
         end
      end
   end

   // A new issue to the same rd as this cycle's write belongs to a younger instruction, so set wins.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (wb.issue_valid_i) set_mask[wb.issue_rd_i] = 1'b1;
      if (rf_we_q)          clr_mask[rf_waddr_q]    = 1'b1;
      pending_d    = (pending_q & ~clr_mask) | set_mask;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pending_q <= '0;
      else         pending_q <= pending_d;
   end

   assign wb.rf_we_o    = rf_we_q;
   assign wb.rf_waddr_o = rf_waddr_q;
   assign wb.rf_wdata_o = rf_wdata_q;
   assign wb.pending_o  = pending_q;
   assign wb.busy_o     = !fifo_empty | rf_we_q | (|pending_q);

   write_without_pending: assert property (
      @(posedge clk_i) disable iff (!rst_ni) rf_we_q |-> pending_q[rf_waddr_q]
   );

endmodule
